// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU operand/opcode sequencer:
//   - state_t   : sequencer states (IDLE / EXEC / DONE)
//   - CODIGO_W  : width of the ALU operation code
//   - WIDTH_DEF : default operand/result width
//   - CNT_W     : width of the EXEC wait counter (covers ALU_LAT-1 up to 14)
// Optional feature macro used by the top module: ALU_SEQ_CHAIN_EN
// -----------------------------------------------------------------------------
package alu_pkg;

   localparam int CODIGO_W  = 3;
   localparam int WIDTH_DEF = 4;
   localparam int CNT_W     = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/alu_seq_cnt.sv
// -----------------------------------------------------------------------------
// alu_seq_cnt
// Down-counter with synchronous load, zero flag and asynchronous reset.
// Used to time how long the ALU inputs are held before the result is sampled.
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous reset, active-high (count -> 0)
//   load     : load load_val on the next edge (has priority over dec)
//   load_val : value to load
//   dec      : decrement on the next edge; saturates at zero
//   count    : current counter value
//   zero     : count == 0
// -----------------------------------------------------------------------------
module alu_seq_cnt #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] count,
   output logic         zero
);

   // NOTE: sequential state is always assigned with <= so every flop samples
   // the pre-edge values of its inputs, independent of block ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/alu_secuenciador.sv
// -----------------------------------------------------------------------------
// alu_secuenciador
// Upstream operand/opcode sequencer for the ALU. Accepts one request at a time
// over a valid/ready handshake, drives and holds OP1/OP2/codigo for ALU_LAT
// cycles, samples the ALU result and offers it downstream over a second
// valid/ready handshake.
//
// Parameters:
//   WIDTH   : operand and result width
//   ALU_LAT : cycles the ALU inputs are held before sampling (1..15)
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   in_valid / in_ready            : request handshake
//   in_op1, in_op2, in_codigo      : request payload
//   in_chain                       : (ALU_SEQ_CHAIN_EN only) load OP1 from out_res
//   OP1, OP2, codigo               : registered operands/code driven to the ALU
//   alu_res                        : combinational ALU result
//   out_valid / out_ready          : result handshake
//   out_res, out_codigo            : captured result and its operation code
//
// Optional feature macro: ALU_SEQ_CHAIN_EN (accumulator-style chaining).
// -----------------------------------------------------------------------------
module alu_secuenciador
   import alu_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEF,
   parameter int ALU_LAT = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WIDTH-1:0]    in_op1,
   input  logic [WIDTH-1:0]    in_op2,
   input  logic [CODIGO_W-1:0] in_codigo,
`ifdef ALU_SEQ_CHAIN_EN
   input  logic                in_chain,
`endif
   output logic [WIDTH-1:0]    OP1,
   output logic [WIDTH-1:0]    OP2,
   output logic [CODIGO_W-1:0] codigo,
   input  logic [WIDTH-1:0]    alu_res,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WIDTH-1:0]    out_res,
   output logic [CODIGO_W-1:0] out_codigo
);

   // Stop elaboration on an out-of-range latency; the counter cannot express it.
   generate
      if ((ALU_LAT < 1) || (ALU_LAT > 15)) begin : g_bad_lat
         $error("alu_secuenciador: ALU_LAT must be in 1..15");
      end
   endgenerate

   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(ALU_LAT - 1);

   state_t             state;
   logic               accept;
   logic               cnt_zero;
   logic [CNT_W-1:0]   cnt_val;
   logic [WIDTH-1:0]   op1_next;

   // in_ready is a registered copy of "state == IDLE", so acceptance never
   // depends combinationally on in_valid.
   assign accept = in_ready && in_valid;

`ifdef ALU_SEQ_CHAIN_EN
   // Chaining feeds the previous captured result back as operand 1.
   assign op1_next = in_chain ? out_res : in_op1;
`else
   assign op1_next = in_op1;
`endif

   alu_seq_cnt #(
      .W (CNT_W)
   ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (accept),
      .load_val (LAT_LOAD),
      .dec      (state == EXEC),
      .count    (cnt_val),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         OP1        <= '0;
         OP2        <= '0;
         codigo     <= '0;
         out_res    <= '0;
         out_codigo <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  OP1      <= op1_next;
                  OP2      <= in_op2;
                  codigo   <= in_codigo;
                  in_ready <= 1'b0;
                  state    <= EXEC;
               end
            end
            EXEC: begin
               // The counter reaches zero on the last cycle of the hold window;
               // alu_res is sampled on the edge that ends that cycle.
               if (cnt_zero) begin
                  out_res    <= alu_res;
                  out_codigo <= codigo;
                  out_valid  <= 1'b1;
                  state      <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

   // cnt_val is only observed through cnt_zero.
   logic unused_cnt;
   assign unused_cnt = ^cnt_val;

endmodule

// File: tb/tb_alu_secuenciador.sv
// -----------------------------------------------------------------------------
// tb_alu_secuenciador
// Two sequencer instances: dut_a (ALU_LAT=1) and dut_b (ALU_LAT=3). The bench
// plays the ALU for both, runs directed steps, then a randomized run on dut_b
// compared against a transaction-level model (queue of outstanding ops plus
// the cycle each op was accepted).
// -----------------------------------------------------------------------------
module tb_alu_secuenciador;

   localparam int W     = 4;
   localparam int LAT_A = 1;
   localparam int LAT_B = 3;

   typedef struct {
      logic [W-1:0] res;
      logic [2:0]   cod;
   } txn_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // dut_a signals
   logic         in_valid_a = 1'b0, in_ready_a, out_valid_a, out_ready_a = 1'b0;
   logic [W-1:0] in_op1_a = '0, in_op2_a = '0, op1_a, op2_a, alu_res_a, out_res_a;
   logic [2:0]   in_cod_a = '0, cod_a, out_cod_a;
   // dut_b signals
   logic         in_valid_b = 1'b0, in_ready_b, out_valid_b, out_ready_b = 1'b0;
   logic [W-1:0] in_op1_b = '0, in_op2_b = '0, op1_b, op2_b, alu_res_b, out_res_b;
   logic [2:0]   in_cod_b = '0, cod_b, out_cod_b;
   logic         ovr_b = 1'b0;
   logic [W-1:0] ovr_val_b = '0;
`ifdef ALU_SEQ_CHAIN_EN
   logic         in_chain_a = 1'b0;
   logic         in_chain_b = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   // Behavioural ALU used both as the DUT's ALU and as the reference.
   function automatic logic [W-1:0] alu_model(logic [W-1:0] a, logic [W-1:0] b, logic [2:0] c);
      case (c)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return ~a;
         3'd6:    return a << 1;
         default: return b;
      endcase
   endfunction

   assign alu_res_a = alu_model(op1_a, op2_a, cod_a);
   assign alu_res_b = ovr_b ? ovr_val_b : alu_model(op1_b, op2_b, cod_b);

   alu_secuenciador #(.WIDTH(W), .ALU_LAT(LAT_A)) dut_a (
      .clk(clk), .rst(rst),
      .in_valid(in_valid_a), .in_ready(in_ready_a),
      .in_op1(in_op1_a), .in_op2(in_op2_a), .in_codigo(in_cod_a),
`ifdef ALU_SEQ_CHAIN_EN
      .in_chain(in_chain_a),
`endif
      .OP1(op1_a), .OP2(op2_a), .codigo(cod_a),
      .alu_res(alu_res_a),
      .out_valid(out_valid_a), .out_ready(out_ready_a),
      .out_res(out_res_a), .out_codigo(out_cod_a)
   );

   alu_secuenciador #(.WIDTH(W), .ALU_LAT(LAT_B)) dut_b (
      .clk(clk), .rst(rst),
      .in_valid(in_valid_b), .in_ready(in_ready_b),
      .in_op1(in_op1_b), .in_op2(in_op2_b), .in_codigo(in_cod_b),
`ifdef ALU_SEQ_CHAIN_EN
      .in_chain(in_chain_b),
`endif
      .OP1(op1_b), .OP2(op2_b), .codigo(cod_b),
      .alu_res(alu_res_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b),
      .out_res(out_res_b), .out_codigo(out_cod_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle just past the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   txn_t q[$];
   txn_t t;
   int   cyc;
   int   acc_cyc;
   logic acc, dlv, exp_ov;

   initial begin
      // ---- 1. reset then idle ------------------------------------------------
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      step();
      chk("rst_in_ready_a", in_ready_a, 1);
      chk("rst_out_valid_a", out_valid_a, 0);
      chk("rst_op1_a", op1_a, 0);
      chk("rst_op2_a", op2_a, 0);
      chk("rst_codigo_a", cod_a, 0);
      chk("rst_out_res_a", out_res_a, 0);
      chk("rst_in_ready_b", in_ready_b, 1);
      chk("rst_out_valid_b", out_valid_b, 0);

      // ---- 2. single op, ALU_LAT=1 ------------------------------------------
      out_ready_a = 1'b0;
      in_valid_a = 1'b1; in_op1_a = 4'h1; in_op2_a = 4'h0; in_cod_a = 3'b001;
      step();
      in_valid_a = 1'b0;
      chk("acc_op1", op1_a, 4'h1);
      chk("acc_op2", op2_a, 4'h0);
      chk("acc_codigo", cod_a, 3'b001);
      chk("acc_in_ready", in_ready_a, 0);
      chk("acc_out_valid", out_valid_a, 0);
      step();
      chk("lat1_out_valid", out_valid_a, 1);
      chk("lat1_out_res", out_res_a, alu_model(4'h1, 4'h0, 3'b001));
      chk("lat1_out_codigo", out_cod_a, 3'b001);

      // ---- 3. backpressure, new request pending ------------------------------
      in_valid_a = 1'b1; in_op1_a = 4'h7; in_op2_a = 4'h2; in_cod_a = 3'd0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_out_valid", out_valid_a, 1);
         chk("bp_out_res", out_res_a, 4'h1);
         chk("bp_out_codigo", out_cod_a, 3'b001);
         chk("bp_in_ready", in_ready_a, 0);
         chk("bp_op1_held", op1_a, 4'h1);
      end
      out_ready_a = 1'b1;
      step();
      chk("drain_out_valid", out_valid_a, 0);
      chk("drain_in_ready", in_ready_a, 1);
      chk("drain_op1_held", op1_a, 4'h1);
      step();
      in_valid_a = 1'b0;
      chk("acc2_op1", op1_a, 4'h7);
      chk("acc2_op2", op2_a, 4'h2);
      chk("acc2_codigo", cod_a, 3'd0);
      step();
      chk("op2_out_valid", out_valid_a, 1);
      chk("op2_out_res", out_res_a, 4'h9);
      step();
      chk("done_one_cycle", out_valid_a, 0);
      chk("done_in_ready", in_ready_a, 1);

`ifdef ALU_SEQ_CHAIN_EN
      // ---- 6. chaining ------------------------------------------------------
      in_valid_a = 1'b1; in_op1_a = 4'h3; in_op2_a = 4'h3; in_cod_a = 3'd0; in_chain_a = 1'b0;
      step();
      in_valid_a = 1'b0;
      step();
      chk("chain_first_res", out_res_a, 4'h6);
      step();
      in_valid_a = 1'b1; in_op1_a = 4'hF; in_op2_a = 4'h1; in_cod_a = 3'd0; in_chain_a = 1'b1;
      step();
      in_valid_a = 1'b0; in_chain_a = 1'b0;
      chk("chain_op1", op1_a, 4'h6);
      step();
      chk("chain_res", out_res_a, 4'h7);
      step();
`endif

      // ---- 4. ALU_LAT=3, only the final EXEC cycle is sampled ----------------
      out_ready_b = 1'b1;
      in_valid_b = 1'b1; in_op1_b = 4'h5; in_op2_b = 4'h3; in_cod_b = 3'd0;
      step();
      in_valid_b = 1'b0;
      ovr_b = 1'b1; ovr_val_b = 4'hA;
      chk("lat3_op1_c0", op1_b, 4'h5);
      chk("lat3_op2_c0", op2_b, 4'h3);
      step();
      chk("lat3_op1_c1", op1_b, 4'h5);
      chk("lat3_ov_c1", out_valid_b, 0);
      step();
      ovr_val_b = 4'hC;
      chk("lat3_op2_c2", op2_b, 4'h3);
      chk("lat3_ov_c2", out_valid_b, 0);
      step();
      ovr_b = 1'b0;
      chk("lat3_out_valid", out_valid_b, 1);
      chk("lat3_out_res", out_res_b, 4'hC);
      chk("lat3_out_codigo", out_cod_b, 3'd0);
      step();
      chk("lat3_done_one", out_valid_b, 0);
      chk("lat3_in_ready", in_ready_b, 1);

      // ---- 5. reset mid-EXEC --------------------------------------------------
      in_valid_b = 1'b1; in_op1_b = 4'h9; in_op2_b = 4'h4; in_cod_b = 3'd4;
      step();
      in_valid_b = 1'b0;
      step();
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_op1", op1_b, 0);
      chk("mid_rst_op2", op2_b, 0);
      chk("mid_rst_codigo", cod_b, 0);
      chk("mid_rst_in_ready", in_ready_b, 1);
      chk("mid_rst_out_valid", out_valid_b, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("post_rst_no_ov", out_valid_b, 0);
      end

      // ---- randomized run on dut_b against a transaction model ---------------
      cyc = 0;
      acc_cyc = 0;
      for (int i = 0; i < 300; i++) begin
         exp_ov = (q.size() != 0) && ((cyc - acc_cyc) >= LAT_B);
         chk("rnd_in_ready", in_ready_b, (q.size() == 0));
         chk("rnd_out_valid", out_valid_b, exp_ov);
         if (exp_ov) begin
            chk("rnd_out_res", out_res_b, q[0].res);
            chk("rnd_out_codigo", out_cod_b, q[0].cod);
         end
         in_valid_b  = ($urandom_range(0, 1) == 1);
         out_ready_b = ($urandom_range(0, 3) != 0);
         in_op1_b    = W'($urandom);
         in_op2_b    = W'($urandom);
         in_cod_b    = 3'($urandom);
         acc = in_valid_b && (q.size() == 0);
         dlv = exp_ov && out_ready_b;
         step();
         cyc++;
         if (dlv) void'(q.pop_front());
         if (acc) begin
            t.res = alu_model(in_op1_b, in_op2_b, in_cod_b);
            t.cod = in_cod_b;
            q.push_back(t);
            acc_cyc = cyc;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_secuenciador.md
Name: alu_secuenciador

Overview:
Upstream operand/opcode sequencer for the ALU block.
- Accepts operation requests (two operands plus a 3-bit code) over a valid/ready handshake.
- Drives OP1/OP2/codigo to the ALU and holds them stable while the ALU result settles.
- Captures the ALU result and presents it downstream over a second valid/ready handshake.
- Processes one operation at a time; no overlap.

Parameters:
WIDTH, 4, operand and result width in bits.
ALU_LAT, 1, cycles the ALU inputs are held before the result is sampled (1..15).

Ports:
clk  in  1  system clock, all state updates on rising edge.
rst  in  1  asynchronous reset, active-high.
in_valid  in  1  request present.
in_ready  out  1  sequencer can accept a request.
in_op1  in  WIDTH  first operand of request.
in_op2  in  WIDTH  second operand of request.
in_codigo  in  3  operation code of request.
OP1  out  WIDTH  operand 1 driven to ALU.
OP2  out  WIDTH  operand 2 driven to ALU.
codigo  out  3  operation code driven to ALU.
alu_res  in  WIDTH  combinational ALU result.
out_valid  out  1  captured result available.
out_ready  in  1  downstream accepts result.
out_res  out  WIDTH  captured result.
out_codigo  out  3  code of the operation that produced out_res.

Behaviour:
Reset (async, immediate, any state):
- State goes to IDLE.
- OP1, OP2, codigo, out_res and out_codigo all go to 0.
- out_valid goes to 0 and in_ready goes to 1.
- The wait counter goes to 0.

States:
- IDLE: in_ready=1. When in_valid=1, on the clock edge latch in_op1/in_op2/in_codigo into OP1/OP2/codigo, load counter with ALU_LAT-1, go to EXEC.
- EXEC: in_ready=0; OP1/OP2/codigo held constant. The counter decrements each cycle.
- EXEC exit: on the cycle the counter is 0, sample alu_res into out_res and codigo into out_codigo, set out_valid=1, go to DONE.
- DONE: out_valid=1; out_res and out_codigo held. When out_ready=1, clear out_valid on the edge and go to IDLE.

Latency:
- The request handshake edge is the edge at which in_valid=1 and in_ready=1.
- out_valid rises ALU_LAT edges after that handshake edge.
- With ALU_LAT=1, out_valid rises on the edge after acceptance.

Handshake rules:
- A transfer happens only when valid=1 and ready=1 on the same edge.
- in_ready depends only on state, never combinationally on in_valid.
- in_ready stays 0 in DONE; no accept-while-draining.
- Back-to-back throughput is one operation per ALU_LAT+2 cycles.

Hold and data rules:
- OP1/OP2/codigo keep their last values in IDLE and DONE; they change only on acceptance.
- All 8 code values pass through unmodified; decoding is the ALU's job.
- No width change: out_res is exactly alu_res as sampled.

Boundary conditions:
- out_ready held high continuously: DONE lasts exactly 1 cycle.
- in_valid deasserted during EXEC/DONE: ignored.
- Reset asserted mid-EXEC: operation discarded, no out_valid pulse.
- ALU_LAT=0 is illegal; elaboration is stopped when ALU_LAT is outside 1..15.

Optional Feature:
Macro: ALU_SEQ_CHAIN_EN
- Defined: adds input port in_chain (1 bit). On acceptance with in_chain=1, OP1 is loaded from the current out_res register instead of in_op1. This allows accumulator-style chaining. in_op2 and in_codigo are still used.
- Not defined: port absent; OP1 is always loaded from in_op1.

Decomposition:
Shared package/include alu_pkg:
- State encoding constants: IDLE=2'd0, EXEC=2'd1, DONE=2'd2.
- CODIGO_W=3.
- Default WIDTH constant.

Sub-module: alu_seq_cnt, a down-counter with load, zero flag and async reset, used for the EXEC wait. Everything else lives in the top module.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, release -> in_ready=1, out_valid=0, OP1=OP2=0, codigo=0.
2. Single op, ALU_LAT=1: in_op1=4'h1, in_op2=4'h0, in_codigo=3'b001, in_valid=1 for 1 cycle; bench models the ALU (alu_res=4'h1) -> OP1=1, OP2=0, codigo=001 the edge after; out_valid=1 one edge later with out_res=4'h1, out_codigo=001.
3. Backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid, out_res and out_codigo stable; in_ready=0 throughout; a new in_valid is not accepted until out_ready=1.
4. ALU_LAT=3: request with in_op1=4'h5, in_op2=4'h3 -> OP1/OP2 held 3 cycles; alu_res changed by the bench before the final EXEC cycle -> only the value on the final EXEC cycle is captured.
5. Reset mid-EXEC (ALU_LAT=3): assert rst during cycle 2 of EXEC -> immediate return to reset values; no out_valid pulse afterward.
6. ALU_SEQ_CHAIN_EN: first op yields out_res=4'h6; second request with in_chain=1, in_op1=4'hF -> OP1=4'h6, not 4'hF.
